ps2_host_tx: RTL

//   Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the device: inhibit, request-to-send, 8 data
// bits LSB first, odd parity, stop, then samples the device ACK.
// Lines are driven through open-drain "pull low" enables.
// Optional build macro: PS2_TX_TIMEOUT_EN enables a watchdog that aborts a
// frame when the device stops clocking for TIMEOUT_CYCLES cycles.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic       kb_clk_low,
  output logic       kb_data_low,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_ACK       = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  logic [2:0]       r_state;
  logic [9:0]       r_shift;
  logic [3:0]       r_bit_cnt;
  logic [INH_W-1:0] r_inh_cnt;
  logic             r_ack_ok;
  logic             r_clk_low;
  logic             r_data_low;
  logic             r_done;
  logic             r_error;

  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_data_s1, r_data_s2;
  logic w_fall;
  logic w_timeout;

  // Two-flop synchronisers for both lines plus a delayed copy of the clock for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_clk_s3  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_clk_s1  <= kb_clk;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
      r_data_s1 <= kb_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_fall = r_clk_s3 & ~r_clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_active;

  assign w_to_active = (r_state == ST_RTS) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
  // A fall proves the device is alive, so it always wins over the watchdog
  assign w_timeout   = w_to_active && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles since the last device clock fall while the device owns the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (!w_to_active || w_fall || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout = 1'b0;
`endif

  // Main frame sequencer; all line enables are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_inh_cnt  <= '0;
      r_ack_ok   <= 1'b0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_shift    <= {1'b1, ~^tx_data, tx_data};
            r_error    <= 1'b0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_ack_ok   <= 1'b0;
            r_clk_low  <= 1'b1;
            // With a one-cycle inhibit the start bit must already be there
            r_data_low <= (INHIBIT_CYCLES == 1);
            r_state    <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          // Start bit goes low during the final inhibit cycle
          if (int'(r_inh_cnt) == INHIBIT_CYCLES - 2) begin
            r_data_low <= 1'b1;
          end
          if (int'(r_inh_cnt) == INHIBIT_CYCLES - 1) begin
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b1;
            r_state    <= ST_RTS;
          end
        end
        ST_RTS: begin
          if (w_fall) begin
            r_data_low <= ~r_shift[0];
            r_shift    <= {1'b0, r_shift[9:1]};
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd9) begin
              r_state <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (w_fall) begin
            if (!r_data_s2) begin
              r_ack_ok <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
            r_state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (r_clk_s2 && r_data_s2) begin
            r_done  <= r_ack_ok;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase

      // Watchdog abort overrides whatever the sequencer decided this cycle
      if (w_timeout) begin
        r_clk_low  <= 1'b0;
        r_data_low <= 1'b0;
        r_error    <= 1'b1;
        r_done     <= 1'b0;
        r_state    <= ST_IDLE;
      end
    end
  end

  assign kb_clk_low  = r_clk_low;
  assign kb_data_low = r_data_low;
  assign tx_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign error       = r_error;

endmodule
